// File: rtl/uart_serial_core_pkg.sv
// Shared 8N1 frame constants and FSM state types for the UART core.
// Imported by the transmitter, receiver and top-level wrapper.
package uart_serial_core_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_RECV
    } rx_state_t;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 receiver: synchronizes serial_in, mid-bit samples, holds last byte.
// Ports: clk, rst, serial_in, data_out[7:0], data_out_valid, data_out_ready.
module uart_receiver
    import uart_serial_core_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SAMPLE_PT = CW'(SAMPLE_TIME);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    rx_state_t state, state_nxt;

    logic                 sync_q1;
    logic                 sync_q2;
    logic [DATA_BITS-1:0] shift;
    logic [CW-1:0]        sym_cnt;
    logic [3:0]           bit_cnt;
    logic                 sample;
    logic                 last;
    logic                 good;

    assign sample = (state == RX_RECV) && (sym_cnt == SAMPLE_PT);
    assign last   = sample && (bit_cnt == BIT_LAST);
    assign good   = last && (sync_q2 == STOP_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= serial_in;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RX_IDLE: begin
                if (sync_q2 == START_BIT) begin
                    state_nxt = RX_RECV;
                end
            end
            RX_RECV: begin
                if (last) begin
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // The start sample is shifted in first and falls out after eight data
    // samples, leaving data[0] in bit 0 when the stop sample arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '0;
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == RX_IDLE) begin
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
            if (sample && !last) begin
                shift   <= {sync_q2, shift[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // A fresh byte beats a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (good) begin
            data_out       <= shift;
            data_out_valid <= 1'b1;
        end else if (data_out_valid && data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 transmitter: latches a byte on valid/ready, shifts out LSB first.
// Ports: clk, rst, data_in[7:0], data_in_valid, data_in_ready, serial_out.
module uart_transmitter
    import uart_serial_core_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME + 1);
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_t state, state_nxt;

    logic [FRAME_BITS-1:0] shift;
    logic [CW-1:0]         sym_cnt;
    logic [3:0]            bit_cnt;
    logic                  sym_end;
    logic                  frame_end;
    logic                  accept;

    assign sym_end   = (sym_cnt == SYM_LAST);
    assign frame_end = sym_end && (bit_cnt == BIT_LAST);
    assign accept    = data_in_valid && (state == TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_in_ready = 1'b0;
        serial_out    = STOP_BIT;
        unique case (state)
            TX_IDLE: begin
                data_in_ready = 1'b1;
                if (data_in_valid) begin
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                serial_out = shift[0];
                if (frame_end) begin
                    state_nxt = TX_IDLE;
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // The whole frame is preloaded, so bit 0 is always the symbol on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '1;
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shift   <= {STOP_BIT, data_in, START_BIT};
            sym_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == TX_SEND) begin
            if (sym_end) begin
                sym_cnt <= '0;
                bit_cnt <= frame_end ? 4'd0 : bit_cnt + 4'd1;
                shift   <= {STOP_BIT, shift[FRAME_BITS-1:1]};
            end else begin
                sym_cnt <= sym_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_serial_core.sv
// Full-duplex 8N1 UART: transmitter and receiver side by side.
// Ports: clk, rst, data_in/valid/ready, data_out/valid/ready, serial_in/out.
module uart_serial_core
    import uart_serial_core_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    input  logic                 serial_in,
    output logic                 serial_out
);

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    uart_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

endmodule

// File: tb/tb_uart_serial_core.sv
// Directed bench: fast A->B loopback pair plus a default-rate instance C.
// C checks exact 1085-cycle symbol timing; A/B cover RX paths and errors.
module tb_uart_serial_core;

    localparam int FCLK = 125_000_000;
    localparam int FBAUD = 1_000_000;
    localparam int SETP = FCLK / FBAUD;
    localparam int SETD = 125_000_000 / 115_200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_din = '0, a_dout;
    logic a_dv = 0, a_rdy, a_dov, a_dor = 0, a_tx;
    logic [7:0] b_din = '0, b_dout;
    logic b_dv = 0, b_rdy, b_dov, b_dor = 0, b_tx, b_rx;
    logic b_sel = 0, b_drv = 1;
    logic [7:0] c_din = '0, c_dout;
    logic c_dv = 0, c_rdy, c_dov, c_tx;

    assign b_rx = b_sel ? b_drv : a_tx;

    uart_serial_core #(.CLOCK_FREQ(FCLK), .BAUD_RATE(FBAUD)) u_a (
        .clk(clk), .rst(rst),
        .data_in(a_din), .data_in_valid(a_dv), .data_in_ready(a_rdy),
        .data_out(a_dout), .data_out_valid(a_dov),
        .data_out_ready(a_dor),
        .serial_in(b_tx), .serial_out(a_tx)
    );

    uart_serial_core #(.CLOCK_FREQ(FCLK), .BAUD_RATE(FBAUD)) u_b (
        .clk(clk), .rst(rst),
        .data_in(b_din), .data_in_valid(b_dv), .data_in_ready(b_rdy),
        .data_out(b_dout), .data_out_valid(b_dov),
        .data_out_ready(b_dor),
        .serial_in(b_rx), .serial_out(b_tx)
    );

    uart_serial_core u_c (
        .clk(clk), .rst(rst),
        .data_in(c_din), .data_in_valid(c_dv), .data_in_ready(c_rdy),
        .data_out(c_dout), .data_out_valid(c_dov),
        .data_out_ready(1'b0),
        .serial_in(1'b1), .serial_out(c_tx)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] d);
        int k;
        k = 0;
        while (!a_rdy && k < 20 * SETP) begin
            tick(1);
            k++;
        end
        checks++;
        if (a_rdy !== 1'b1) begin
            $display("FAIL send_wait_ready got=%b want=1", a_rdy);
            errors++;
        end
        a_din = d;
        a_dv = 1'b1;
        tick(1);
        a_dv = 1'b0;
        checks++;
        if (a_rdy !== 1'b0) begin
            $display("FAIL send_ready_drop got=%b want=0", a_rdy);
            errors++;
        end
    endtask

    task automatic wait_b_valid(input int lim);
        int k;
        k = 0;
        while (b_dov !== 1'b1 && k < lim) begin
            tick(1);
            k++;
        end
        checks++;
        if (b_dov !== 1'b1) begin
            $display("FAIL rx_valid_timeout got=%b want=1", b_dov);
            errors++;
        end
    endtask

    task automatic pulse_b_ready();
        b_dor = 1'b1;
        tick(1);
        b_dor = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (a_tx !== 1'b1 || b_tx !== 1'b1 || c_tx !== 1'b1) begin
            $display("FAIL reset_lines got=%b%b%b want=111",
                     a_tx, b_tx, c_tx);
            errors++;
        end
        checks++;
        if (a_rdy !== 1'b1 || c_rdy !== 1'b1) begin
            $display("FAIL reset_ready got=%b%b want=11", a_rdy, c_rdy);
            errors++;
        end
        checks++;
        if (b_dov !== 1'b0 || b_dout !== 8'h00) begin
            $display("FAIL reset_rx got=%b/%h want=0/00", b_dov, b_dout);
            errors++;
        end
    endtask

    task automatic test_loopback();
        int t0;
        logic [7:0] exp;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            exp = 8'h11 + 8'(i);
            send_a(exp);
            wait_b_valid(11 * SETP);
            checks++;
            if (b_dout !== exp) begin
                $display("FAIL loop_data[%0d] got=%h want=%h",
                         i, b_dout, exp);
                errors++;
            end
            pulse_b_ready();
            checks++;
            if (b_dov !== 1'b0) begin
                $display("FAIL loop_consume[%0d] got=%b want=0", i, b_dov);
                errors++;
            end
        end
        checks++;
        if (cyc - t0 >= 10 * 11 * SETP) begin
            $display("FAIL loop_duration got=%0d want<%0d",
                     cyc - t0, 10 * 11 * SETP);
            errors++;
        end
    endtask

    task automatic test_hold();
        tick(10);
        checks++;
        if (b_dout !== 8'h1A || a_tx !== 1'b1) begin
            $display("FAIL hold got=%h/%b want=1a/1", b_dout, a_tx);
            errors++;
        end
    endtask

    task automatic test_extra_consume();
        pulse_b_ready();
        tick(1);
        checks++;
        if (b_dov !== 1'b0 || b_dout !== 8'h1A) begin
            $display("FAIL extra_consume got=%b/%h want=0/1a",
                     b_dov, b_dout);
            errors++;
        end
    endtask

    task automatic test_bit_timing();
        logic [9:0] fr;
        int bad_tx;
        int bad_rdy;
        fr = {1'b1, 8'hA5, 1'b0};
        checks++;
        if (c_rdy !== 1'b1) begin
            $display("FAIL c_idle_ready got=%b want=1", c_rdy);
            errors++;
        end
        c_din = 8'hA5;
        c_dv = 1'b1;
        tick(1);
        c_dv = 1'b0;
        for (int s = 0; s < 10; s++) begin
            bad_tx = 0;
            bad_rdy = 0;
            for (int k = 0; k < SETD; k++) begin
                if (c_tx !== fr[s]) bad_tx++;
                if (c_rdy !== 1'b0) bad_rdy++;
                tick(1);
            end
            checks++;
            if (bad_tx != 0 || bad_rdy != 0) begin
                $display("FAIL sym[%0d] tx_bad=%0d rdy_bad=%0d want=%b/0",
                         s, bad_tx, bad_rdy, fr[s]);
                errors++;
            end
        end
        checks++;
        if (c_rdy !== 1'b1 || c_tx !== 1'b1) begin
            $display("FAIL frame_end got=%b/%b want=1/1", c_rdy, c_tx);
            errors++;
        end
    endtask

    task automatic test_framing();
        logic [9:0] fr;
        fr = {1'b0, 8'h3C, 1'b0};
        b_drv = 1'b1;
        b_sel = 1'b1;
        tick(2);
        for (int s = 0; s < 10; s++) begin
            b_drv = fr[s];
            tick(SETP);
        end
        b_drv = 1'b1;
        tick(2 * SETP);
        checks++;
        if (b_dov !== 1'b0 || b_dout !== 8'h1A) begin
            $display("FAIL framing got=%b/%h want=0/1a", b_dov, b_dout);
            errors++;
        end
        tick(12 * SETP);
        pulse_b_ready();
        b_sel = 1'b0;
        tick(1);
        checks++;
        if (b_dov !== 1'b0) begin
            $display("FAIL framing_clear got=%b want=0", b_dov);
            errors++;
        end
    endtask

    task automatic test_overrun();
        int k;
        send_a(8'h5A);
        wait_b_valid(11 * SETP);
        checks++;
        if (b_dout !== 8'h5A) begin
            $display("FAIL over_first got=%h want=5a", b_dout);
            errors++;
        end
        send_a(8'hC3);
        tick(5 * SETP);
        checks++;
        if (b_dov !== 1'b1 || b_dout !== 8'h5A) begin
            $display("FAIL over_mid got=%b/%h want=1/5a", b_dov, b_dout);
            errors++;
        end
        k = 0;
        while (b_dout === 8'h5A && k < 11 * SETP) begin
            tick(1);
            k++;
        end
        checks++;
        if (b_dout !== 8'hC3 || b_dov !== 1'b1) begin
            $display("FAIL overrun got=%h/%b want=c3/1", b_dout, b_dov);
            errors++;
        end
        pulse_b_ready();
    endtask

    task automatic test_reset_midframe();
        send_a(8'h77);
        tick(5 * SETP);
        rst = 1'b1;
        tick(1);
        checks++;
        if (a_tx !== 1'b1 || a_rdy !== 1'b1) begin
            $display("FAIL midreset_tx got=%b/%b want=1/1", a_tx, a_rdy);
            errors++;
        end
        checks++;
        if (b_dout !== 8'h00 || b_dov !== 1'b0) begin
            $display("FAIL midreset_rx got=%h/%b want=00/0", b_dout, b_dov);
            errors++;
        end
        rst = 1'b0;
        tick(12 * SETP);
        checks++;
        if (b_dov !== 1'b0) begin
            $display("FAIL midreset_drop got=%b want=0", b_dov);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_hold();
        test_extra_consume();
        test_bit_timing();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
